// File: rtl/serial_subtractor_26bit_pkg.sv
// Shared definitions for the bit-serial subtractor and its ripple-carry
// adder companion.
//   state_e   : FSM state encodings (IDLE=0, RUN=1, DONE=2)
//   SUB_WIDTH : default operand width, also used by the ripple-carry adder
package serial_subtractor_26bit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int SUB_WIDTH = 26;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, shared with the ripple-carry adder.
//   i_a, i_b : addend bits
//   i_cin    : carry in
//   o_sum    : sum bit
//   o_cout   : carry out
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/serial_subtractor_26bit.sv
// Multi-cycle digit-serial two's-complement subtractor: A - B computed as
// A + ~B + 1, DIGIT_W bits per clock, through a chain of full_adder cells.
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_valid / o_ready       : operand handshake (accepted only in IDLE)
//   i_minuend, i_subtrahend : operands A and B
//   o_valid / i_ready       : result handshake (held in DONE until taken)
//   o_difference            : (A - B) mod 2^WIDTH
//   o_borrow                : 1 when A < B (unsigned)
module serial_subtractor_26bit
  import serial_subtractor_26bit_pkg::*;
#(
  parameter int WIDTH   = SUB_WIDTH,
  parameter int DIGIT_W = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_minuend,
  input  logic [WIDTH-1:0] i_subtrahend,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_difference,
  output logic             o_borrow
);

  localparam int N_DIGITS = WIDTH / DIGIT_W;
  localparam int CNT_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N_DIGITS - 1);

  if ((WIDTH % DIGIT_W) != 0) begin : g_bad_digit_w
    $error("serial_subtractor_26bit: WIDTH must be a multiple of DIGIT_W");
  end

  state_e               state_q,  state_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic [WIDTH-1:0]     a_q,      a_d;
  logic [WIDTH-1:0]     b_q,      b_d;
  logic [WIDTH-1:0]     res_q,    res_d;
  logic                 carry_q,  carry_d;
  logic [WIDTH-1:0]     diff_q,   diff_d;
  logic                 borrow_q, borrow_d;
  logic                 valid_q,  valid_d;

  logic [DIGIT_W-1:0]       chain_sum;
  logic                     chain_cout;
  logic [WIDTH+DIGIT_W-1:0] res_cat;
  logic [WIDTH-1:0]         res_next;

  // Each cell keeps its own carry net so the chain is a plain feed-forward
  // path rather than bits of one vector depending on each other.
  for (genvar i = 0; i < DIGIT_W; i++) begin : g_fa
    logic c_in;
    logic c_out;
    if (i == 0) begin : g_first
      assign c_in = carry_q;
    end else begin : g_next
      assign c_in = g_fa[i-1].c_out;
    end
    full_adder u_fa (
      .i_a    (a_q[i]),
      .i_b    (b_q[i]),
      .i_cin  (c_in),
      .o_sum  (chain_sum[i]),
      .o_cout (c_out)
    );
  end

  assign chain_cout = g_fa[DIGIT_W-1].c_out;

  // New digit enters at the MSB end; after N_DIGITS shifts the first digit
  // computed has reached bit 0.
  assign res_cat  = {chain_sum, res_q};
  assign res_next = res_cat[WIDTH+DIGIT_W-1:DIGIT_W];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    carry_d  = carry_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    valid_d  = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          a_d     = i_minuend;
          b_d     = ~i_subtrahend;
          carry_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> DIGIT_W;
        b_d     = b_q >> DIGIT_W;
        res_d   = res_next;
        carry_d = chain_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_DIGIT) begin
          diff_d   = res_next;
          borrow_d = ~chain_cout;
          valid_d  = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (i_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      carry_q  <= 1'b1;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      valid_q  <= valid_d;
    end
  end

  // Ready is forced low while reset is asserted, even though state is IDLE.
  assign o_ready      = (state_q == ST_IDLE) && i_rst_n;
  assign o_valid      = valid_q;
  assign o_difference = diff_q;
  assign o_borrow     = borrow_q;

endmodule

// File: tb/tb_serial_subtractor_26bit.sv
// Testbench for serial_subtractor_26bit: one instance at DIGIT_W=1 and one
// at DIGIT_W=2 share operands; sel chooses which one is driven and observed.
module tb_serial_subtractor_26bit;

  logic        clk;
  logic        rst_n;
  logic        vin;
  logic        rdy;
  logic [25:0] op_a;
  logic [25:0] op_b;
  logic        sel;

  logic        r1, v1, bo1, r2, v2, bo2;
  logic [25:0] d1, d2;

  logic        obs_ready, obs_valid, obs_borrow;
  logic [25:0] obs_diff;

  int checks;
  int errors;

  serial_subtractor_26bit #(.DIGIT_W(1)) dut1 (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (vin && !sel),
    .o_ready      (r1),
    .i_minuend    (op_a),
    .i_subtrahend (op_b),
    .o_valid      (v1),
    .i_ready      (rdy),
    .o_difference (d1),
    .o_borrow     (bo1)
  );

  serial_subtractor_26bit #(.DIGIT_W(2)) dut2 (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (vin && sel),
    .o_ready      (r2),
    .i_minuend    (op_a),
    .i_subtrahend (op_b),
    .o_valid      (v2),
    .i_ready      (rdy),
    .o_difference (d2),
    .o_borrow     (bo2)
  );

  assign obs_ready  = sel ? r2  : r1;
  assign obs_valid  = sel ? v2  : v1;
  assign obs_diff   = sel ? d2  : d1;
  assign obs_borrow = sel ? bo2 : bo1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int n_digits();
    return sel ? 13 : 26;
  endfunction

  // Reference: plain 27-bit subtraction; bit 26 is the unsigned borrow.
  function automatic logic [26:0] ref_sub(input logic [25:0] a, input logic [25:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [25:0] a, input logic [25:0] b, input string tag);
    logic [26:0] exp_full;
    int lat;
    bit got;
    exp_full = ref_sub(a, b);
    for (int k = 0; k < 60 && !obs_ready; k++) tick();
    checks++;
    if (obs_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_accept: got %b want 1", tag, obs_ready);
    end
    op_a = a;
    op_b = b;
    vin  = 1'b1;
    tick();
    vin  = 1'b0;
    op_a = 26'($urandom);
    op_b = 26'($urandom);
    got = 0;
    lat = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      lat++;
      if (obs_valid === 1'b1) begin
        got = 1;
        break;
      end
    end
    checks++;
    if (!got || lat != n_digits()) begin
      errors++;
      $display("FAIL %s latency: got %0d (seen=%0d) want %0d", tag, lat, got, n_digits());
    end
    checks++;
    if (obs_diff !== exp_full[25:0]) begin
      errors++;
      $display("FAIL %s difference: got %h want %h", tag, obs_diff, exp_full[25:0]);
    end
    checks++;
    if (obs_borrow !== exp_full[26]) begin
      errors++;
      $display("FAIL %s borrow: got %b want %b", tag, obs_borrow, exp_full[26]);
    end
    tick();
    checks++;
    if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s after_handshake: got valid=%b ready=%b want valid=0 ready=1",
               tag, obs_valid, obs_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vin   = 1'b0;
    rdy   = 1'b1;
    sel   = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (3) tick();
    checks++;
    if ({r1, v1, bo1, r2, v2, bo2} !== 6'b0 || d1 !== 26'd0 || d2 !== 26'd0) begin
      errors++;
      $display("FAIL reset_state: got r=%b%b v=%b%b b=%b%b d1=%h d2=%h want all 0",
               r1, r2, v1, v2, bo1, bo2, d1, d2);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (r1 !== 1'b1 || r2 !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b%b want 11", r1, r2);
    end
  endtask

  task automatic test_directed();
    sel = 1'b0;
    rdy = 1'b1;
    run_op(26'd5, 26'd3, "5-3");
    run_op(26'd3, 26'd5, "3-5");
    run_op(26'd0, 26'd1, "0-1");
    run_op(26'h3FFFFFF, 26'h3FFFFFF, "max-max");
    run_op(26'h2000000, 26'd1, "msb-1");
    run_op(26'd0, 26'd0, "0-0");
  endtask

  task automatic test_backpressure();
    int lat;
    bit got;
    sel = 1'b0;
    rdy = 1'b0;
    for (int k = 0; k < 60 && !obs_ready; k++) tick();
    op_a = 26'd100;
    op_b = 26'd58;
    vin  = 1'b1;
    tick();
    // Keep a second request pending through RUN and DONE.
    op_a = 26'd9;
    op_b = 26'd4;
    got = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (obs_valid === 1'b1) begin
        got = 1;
        break;
      end
    end
    checks++;
    if (!got || obs_diff !== 26'd42) begin
      errors++;
      $display("FAIL bp_first_result: got valid=%b diff=%0d want 1 / 42", got, obs_diff);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (obs_valid !== 1'b1 || obs_diff !== 26'd42 || obs_borrow !== 1'b0 || obs_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: got v=%b d=%0d b=%b r=%b want 1/42/0/0",
                 k, obs_valid, obs_diff, obs_borrow, obs_ready);
      end
    end
    rdy = 1'b1;
    tick();
    checks++;
    if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got v=%b r=%b want 0/1", obs_valid, obs_ready);
    end
    tick();
    vin = 1'b0;
    got = 0;
    lat = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      lat++;
      if (obs_valid === 1'b1) begin
        got = 1;
        break;
      end
    end
    checks++;
    if (!got || lat != 26 || obs_diff !== 26'd5 || obs_borrow !== 1'b0) begin
      errors++;
      $display("FAIL bp_pending_op: got lat=%0d diff=%0d b=%b want 26/5/0", lat, obs_diff, obs_borrow);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int rises;
    sel = 1'b0;
    rdy = 1'b1;
    for (int k = 0; k < 60 && !obs_ready; k++) tick();
    op_a = 26'd50;
    op_b = 26'd20;
    vin  = 1'b1;
    tick();
    vin = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs_valid !== 1'b0 || obs_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_during: got v=%b r=%b want 0/0", obs_valid, obs_ready);
    end
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs_ready !== 1'b1 || obs_valid !== 1'b0 || obs_diff !== 26'd0) begin
      errors++;
      $display("FAIL midreset_after: got r=%b v=%b d=%h want 1/0/0", obs_ready, obs_valid, obs_diff);
    end
    rises = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (obs_valid === 1'b1) rises++;
    end
    checks++;
    if (rises != 0) begin
      errors++;
      $display("FAIL midreset_no_valid: got %0d valid cycles want 0", rises);
    end
    run_op(26'd7, 26'd2, "post_reset 7-2");
  endtask

  task automatic test_digit2();
    sel = 1'b1;
    rdy = 1'b1;
    run_op(26'd1000, 26'd1, "d2 1000-1");
    run_op(26'd3, 26'd5, "d2 3-5");
  endtask

  task automatic test_random();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      rdy = 1'b1;
      for (int k = 0; k < 15; k++) begin
        run_op(26'($urandom), 26'($urandom), sel ? "rand_d2" : "rand_d1");
      end
    end
  endtask

  task automatic test_back_to_back();
    int gap;
    bit seen_low;
    bit done;
    logic [26:0] exp_full;
    for (int s = 0; s < 2; s++) begin
      sel  = s[0];
      rdy  = 1'b1;
      op_a = 26'd1234;
      op_b = 26'd234;
      exp_full = ref_sub(op_a, op_b);
      vin  = 1'b1;
      done = 0;
      for (int k = 0; k < 100 && !done; k++) begin
        tick();
        if (obs_valid === 1'b1) done = 1;
      end
      gap = 0;
      seen_low = 0;
      done = 0;
      for (int k = 0; k < 100 && !done; k++) begin
        tick();
        gap++;
        if (obs_valid === 1'b0) seen_low = 1;
        else if (seen_low) done = 1;
      end
      vin = 1'b0;
      checks++;
      if (!done || gap != n_digits() + 2 || obs_diff !== exp_full[25:0]) begin
        errors++;
        $display("FAIL b2b sel=%0d: got gap=%0d diff=%0d want %0d / %0d",
                 s, gap, obs_diff, n_digits() + 2, exp_full[25:0]);
      end
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_digit2();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
